// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, parity helper.
package uart_pkg;

  // Frame sequencer states, common to the transmitter and the future receiver
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned UART_STATE_W = 3;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Widest legal payload; callers zero-extend into this width
  localparam int unsigned UART_MAX_DATA = 9;

  // Parity bit for a zero-extended payload; zero padding leaves the XOR unchanged
  function automatic logic uart_parity(input logic [UART_MAX_DATA-1:0] data,
                                       input int mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts oversample ticks and flags the last tick of a bit.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic s_tick,
  output logic bit_end
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over a coincident tick; terminal tick wraps to 0
  always_comb begin
    cnt_d   = cnt_q;
    bit_end = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (s_tick) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        bit_end = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Tick counter register
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity, 1/2 stop bits.
// Legal ranges: DATA_BITS 5..9, PARITY 0..2, STOP_BITS 1..2, OVERSAMPLE >= 2.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 s_tick,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != PAR_NONE);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, shreg_shr;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d, par_in;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  // Timer is held clear while idle, so a tick on the accepting cycle is dropped
  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q == ST_IDLE),
    .s_tick  (s_tick),
    .bit_end (bit_end)
  );

  assign shreg_shr = shreg_q >> 1;
  assign par_in    = uart_parity(UART_MAX_DATA'(din), PARITY);

  // Next-state logic; tx_d is the line level for the state being entered
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (wr) begin
          shreg_d    = din;
          par_d      = par_in;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = ST_START;
          tx_d       = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_shr;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = HAS_PAR ? ST_PARITY : ST_STOP;
            tx_d    = HAS_PAR ? par_q : 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_d      = shreg_shr[0];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FSM, datapath and registered outputs; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = (state_q != ST_IDLE);
  assign tx_done = done_q;

endmodule
